// File: rtl/wb_gpio_irq_pkg.sv
`default_nettype none
// =====================================================================
// Package  : wb_gpio_pkg
// Desc     : Register map, slave FSM states and byte-lane merge helper.
// Revision : 1.0 - initial release
// =====================================================================
package wb_gpio_pkg;

    localparam int REG_IDX_W = 3;

    localparam logic [REG_IDX_W-1:0] GPIO_REG_IN      = 3'd0;
    localparam logic [REG_IDX_W-1:0] GPIO_REG_OUT     = 3'd1;
    localparam logic [REG_IDX_W-1:0] GPIO_REG_DIR     = 3'd2;
    localparam logic [REG_IDX_W-1:0] GPIO_REG_RISE_EN = 3'd3;
    localparam logic [REG_IDX_W-1:0] GPIO_REG_FALL_EN = 3'd4;
    localparam logic [REG_IDX_W-1:0] GPIO_REG_STATUS  = 3'd5;
    localparam logic [REG_IDX_W-1:0] GPIO_REG_OUT_SET = 3'd6;
    localparam logic [REG_IDX_W-1:0] GPIO_REG_OUT_CLR = 3'd7;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } wb_state_e;

    // Replace each byte of old_v with the matching byte of new_v where sel is set.
    function automatic logic [31:0] sel_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  sel
    );
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_gpio_irq_if.sv
`default_nettype none
// =====================================================================
// Interface: wb_gpio_irq_if
// Desc     : Wishbone classic slave bus bundle for the GPIO controller.
// Revision : 1.0 - initial release
// =====================================================================
interface wb_gpio_irq_if;
    logic [4:0]  adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [31:0] rdat;
    logic        ack;

    modport master (output adr, wdat, sel, we, cyc, stb, input  rdat, ack);
    modport slave  (input  adr, wdat, sel, we, cyc, stb, output rdat, ack);
endinterface
`default_nettype wire

// File: rtl/wb_gpio_irq_sync.sv
`default_nettype none
// =====================================================================
// Module   : gpio_sync
// Desc     : WIDTH-wide, SYNC_STAGES-deep input synchroniser.
// Revision : 1.0 - initial release
// =====================================================================
module gpio_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign q_o = stage_q[SYNC_STAGES-1];
endmodule
`default_nettype wire

// File: rtl/wb_gpio_irq.sv
`default_nettype none
// =====================================================================
// Module   : wb_gpio_irq
// Desc     : Wishbone GPIO controller: OUT/DIR, atomic set/clear, input
//            sync, and per-pin edge interrupts when WB_GPIO_IRQ_EN is defined.
// Revision : 1.0 - initial release
// =====================================================================
module wb_gpio_irq
    import wb_gpio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    wb_gpio_irq_if.slave     wb,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_dir_o,
    output logic             irq_o
);
    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] r;
        r = '0;
        r[WIDTH-1:0] = v;
        return r;
    endfunction

    wb_state_e            state_q, state_d;
    logic                 w_access, w_wr;
    logic [REG_IDX_W-1:0] w_idx;
    logic [31:0]          w_bits32, w_en32, w_rdata, dat_q, dat_d;
    logic [WIDTH-1:0]     w_bits, w_en, w_sync;
    logic [WIDTH-1:0]     out_q, out_d, dir_q, dir_d;
    logic [31:0]          w_rise_rd, w_fall_rd, w_status_rd;

    gpio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (wb_clk_i),
        .rst_n_i (wb_rst_n_i),
        .d_i     (gpio_i),
        .q_o     (w_sync)
    );

    always_comb begin
        state_d  = ST_IDLE;
        w_access = 1'b0;
        if (state_q == ST_IDLE && wb.cyc && wb.stb && !wb.ack) begin
            state_d  = ST_ACK;
            w_access = 1'b1;
        end
    end

    assign w_wr     = w_access & wb.we;
    assign w_idx    = wb.adr[4:2];
    // Byte-gated write data and the matching lane mask.
    assign w_bits32 = sel_merge(32'h0, wb.wdat, wb.sel);
    assign w_en32   = sel_merge(32'h0, 32'hFFFF_FFFF, wb.sel);
    assign w_bits   = w_bits32[WIDTH-1:0];
    assign w_en     = w_en32[WIDTH-1:0];

    always_comb begin
        out_d = out_q;
        dir_d = dir_q;
        if (w_wr) begin
            case (w_idx)
                GPIO_REG_OUT:     out_d = (out_q & ~w_en) | w_bits;
                GPIO_REG_DIR:     dir_d = (dir_q & ~w_en) | w_bits;
                GPIO_REG_OUT_SET: out_d = out_q | w_bits;
                GPIO_REG_OUT_CLR: out_d = out_q & ~w_bits;
                default:          ;
            endcase
        end
    end

`ifdef WB_GPIO_IRQ_EN
    logic [WIDTH-1:0] prev_q, rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [WIDTH-1:0] status_q, status_d, w_edge;

    assign w_edge = (w_sync & ~prev_q & rise_en_q) | (~w_sync & prev_q & fall_en_q);

    // Edge set is applied after the W1C so a coincident event wins.
    always_comb begin
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        status_d  = status_q;
        if (w_wr) begin
            case (w_idx)
                GPIO_REG_RISE_EN: rise_en_d = (rise_en_q & ~w_en) | w_bits;
                GPIO_REG_FALL_EN: fall_en_d = (fall_en_q & ~w_en) | w_bits;
                GPIO_REG_STATUS:  status_d  = status_q & ~w_bits;
                default:          ;
            endcase
        end
        status_d = status_d | w_edge;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            prev_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
        end else begin
            prev_q    <= w_sync;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
        end
    end

    assign w_rise_rd   = zext(rise_en_q);
    assign w_fall_rd   = zext(fall_en_q);
    assign w_status_rd = zext(status_q);
    assign irq_o       = |status_q;
`else
    assign w_rise_rd   = '0;
    assign w_fall_rd   = '0;
    assign w_status_rd = '0;
    assign irq_o       = 1'b0;
`endif

    always_comb begin
        case (w_idx)
            GPIO_REG_IN:      w_rdata = zext(w_sync);
            GPIO_REG_OUT:     w_rdata = zext(out_q);
            GPIO_REG_DIR:     w_rdata = zext(dir_q);
            GPIO_REG_RISE_EN: w_rdata = w_rise_rd;
            GPIO_REG_FALL_EN: w_rdata = w_fall_rd;
            GPIO_REG_STATUS:  w_rdata = w_status_rd;
            default:          w_rdata = '0;
        endcase
    end

    assign dat_d = (w_access && !wb.we) ? w_rdata : 32'h0;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
            out_q   <= OUT_RESET;
            dir_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            dir_q   <= dir_d;
            dat_q   <= dat_d;
        end
    end

    assign wb.ack     = (state_q == ST_ACK);
    assign wb.rdat    = dat_q;
    assign gpio_o     = out_q;
    assign gpio_dir_o = dir_q;
endmodule
`default_nettype wire
